// File: rtl/seq_mag_cmp_pkg.sv
// Shared types for the sequential magnitude comparator.
// Latency: n/a (types only).
// Backpressure: n/a.
package seq_mag_cmp_pkg;

   // FSM state encoding for seq_mag_cmp.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CMP  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/seq_mag_cmp_if.sv
// Request/result bundle between a client and seq_mag_cmp.
// Latency: n/a (wiring only).
// Backpressure: client may only start when busy is low; start while busy is dropped.
// Signals: start/sgn/a/b (client -> comparator), busy/done/it/eq/gt (comparator -> client).
interface seq_mag_cmp_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sgn;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             it;
   logic             eq;
   logic             gt;

   modport master (
      output start, sgn, a, b,
      input  busy, done, it, eq, gt
   );

   modport slave (
      input  start, sgn, a, b,
      output busy, done, it, eq, gt
   );
endinterface

// File: rtl/seq_mag_cmp_chunk.sv
// Combinational unsigned comparator for one CHUNK-bit slice.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a, b (slice operands); it (a<b), eq (a==b), gt (a>b).
module cmp_chunk #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             it,
   output logic             eq,
   output logic             gt
);
   assign it = (a <  b);
   assign eq = (a == b);
   assign gt = (a >  b);
endmodule

// File: rtl/seq_mag_cmp.sv
// Multi-cycle WIDTH-bit magnitude comparator, MSB-first, CHUNK bits per clock, early exit.
// Latency: done 1..WIDTH/CHUNK cycles after start is accepted (first differing chunk).
// Backpressure: start only accepted in IDLE; ignored while busy (CMP and DONE).
// Ports: clk, rst_b (sync active-low); bus.slave carries start/sgn/a/b in and busy/done/it/eq/gt out.
module seq_mag_cmp #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic           clk,
   input  logic           rst_b,
   seq_mag_cmp_if.slave   bus
);
   import seq_mag_cmp_pkg::*;

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);
   localparam logic [CW-1:0]    LAST_IDX = CW'(NCHUNK - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sa, sb;
   logic             sgn_q;
   logic [CW-1:0]    cnt;
   logic             it_q, eq_q, gt_q;

   logic             load, shift, fin_ne, fin_eq;
   logic [CHUNK-1:0] flip, ca, cb;
   logic             c_it, c_eq, c_gt;
   logic             last;

   // Signed mode: flipping the sign bit of the leading chunk maps two's
   // complement onto offset binary, so an unsigned compare orders correctly.
   assign flip = (sgn_q && (cnt == '0)) ? MSB_MASK : '0;
   assign ca   = sa[WIDTH-1 -: CHUNK] ^ flip;
   assign cb   = sb[WIDTH-1 -: CHUNK] ^ flip;
   assign last = (cnt == LAST_IDX);

   cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a  (ca),
      .b  (cb),
      .it (c_it),
      .eq (c_eq),
      .gt (c_gt)
   );

   always_ff @(posedge clk) begin
      if (!rst_b) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift     = 1'b0;
      fin_ne    = 1'b0;
      fin_eq    = 1'b0;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = ST_CMP;
            end
         end
         ST_CMP: begin
            bus.busy = 1'b1;
            if (!c_eq) begin
               fin_ne    = 1'b1;
               state_nxt = ST_DONE;
            end else if (last) begin
               fin_eq    = 1'b1;
               state_nxt = ST_DONE;
            end else begin
               shift = 1'b1;
            end
         end
         ST_DONE: begin
            bus.busy  = 1'b1;
            bus.done  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         sa    <= '0;
         sb    <= '0;
         sgn_q <= 1'b0;
         cnt   <= '0;
         it_q  <= 1'b0;
         eq_q  <= 1'b0;
         gt_q  <= 1'b0;
      end else begin
         if (load) begin
            sa    <= bus.a;
            sb    <= bus.b;
            sgn_q <= bus.sgn;
            cnt   <= '0;
            it_q  <= 1'b0;
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
         end
         if (shift) begin
            sa  <= sa << CHUNK;
            sb  <= sb << CHUNK;
            cnt <= cnt + CW'(1);
         end
         if (fin_ne) begin
            it_q <= c_it;
            gt_q <= c_gt;
            eq_q <= 1'b0;
         end
         // it/gt were cleared on load, so only eq needs setting here.
         if (fin_eq) eq_q <= 1'b1;
      end
   end

   assign bus.it = it_q;
   assign bus.eq = eq_q;
   assign bus.gt = gt_q;

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Directed bench for seq_mag_cmp (8/2) plus a random sweep on 16/1 and 16/4.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_mag_cmp;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   seq_mag_cmp_if #(.WIDTH(8))  b8  ();
   seq_mag_cmp_if #(.WIDTH(16)) b16a();
   seq_mag_cmp_if #(.WIDTH(16)) b16b();

   seq_mag_cmp #(.WIDTH(8),  .CHUNK(2)) dut8   (.clk(clk), .rst_b(rst_b), .bus(b8));
   seq_mag_cmp #(.WIDTH(16), .CHUNK(1)) dut16a (.clk(clk), .rst_b(rst_b), .bus(b16a));
   seq_mag_cmp #(.WIDTH(16), .CHUNK(4)) dut16b (.clk(clk), .rst_b(rst_b), .bus(b16b));

   // Reference: 1-based index of first differing CHUNK slice, MSB first.
   function automatic int ref_k(input logic [15:0] x, input logic [15:0] y, input int c);
      logic [15:0] d;
      logic [15:0] m;
      d = x ^ y;
      m = (16'd1 << c) - 16'd1;
      for (int i = 0; i < 16 / c; i++)
         if (((d >> (16 - (i + 1) * c)) & m) != 16'd0) return i + 1;
      return 16 / c;
   endfunction

   // Drives one request on the 8-bit DUT, scrambles a/b/sgn while busy and
   // returns cycles from the accepting edge to the done cycle.
   task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                         output int lat, output logic [2:0] res, output int cmp_bad);
      @(negedge clk);
      b8.start = 1'b1; b8.a = ta; b8.b = tb_v; b8.sgn = ts;
      @(negedge clk);
      b8.start = 1'b0; b8.a = ~ta; b8.b = ~tb_v; b8.sgn = ~ts;
      lat = 0; cmp_bad = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (b8.done) break;
         if (b8.it || b8.eq || b8.gt || !b8.busy) cmp_bad++;
      end
      res = {b8.it, b8.eq, b8.gt};
   endtask

   task automatic test_reset();
      rst_b = 1'b0;
      b8.start = 1'b1; b8.a = 8'hFF; b8.b = 8'h00; b8.sgn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({b8.busy, b8.done, b8.it, b8.eq, b8.gt} !== 5'b00000)
            $display("FAIL reset_outputs cycle %0d: got %b want 00000", i,
                     {b8.busy, b8.done, b8.it, b8.eq, b8.gt});
         if ({b8.busy, b8.done, b8.it, b8.eq, b8.gt} !== 5'b00000) errors++;
      end
      b8.start = 1'b0;
      rst_b = 1'b1;
      @(negedge clk);
      checks++;
      if ({b8.busy, b8.done} !== 2'b00) begin
         errors++;
         $display("FAIL reset_release_idle: busy/done got %b want 00", {b8.busy, b8.done});
      end
   endtask

   task automatic test_equal();
      int lat, bad;
      logic [2:0] res;
      issue8(8'h5A, 8'h5A, 1'b0, lat, res, bad);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL equal_latency: got %0d want 4", lat); end
      checks++;
      if (res !== 3'b010) begin errors++; $display("FAIL equal_result it/eq/gt: got %b want 010", res); end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL equal_cmp_outputs: %0d bad CMP cycles want 0", bad); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({b8.done, b8.busy, b8.it, b8.eq, b8.gt} !== 5'b00010) begin
            errors++;
            $display("FAIL equal_hold %0d: done/busy/it/eq/gt got %b want 00010", i,
                     {b8.done, b8.busy, b8.it, b8.eq, b8.gt});
         end
      end
   endtask

   task automatic test_early_and_last();
      logic [7:0] va [4] = '{8'h80, 8'h80, 8'h03, 8'hFE};
      logic [7:0] vb [4] = '{8'h7F, 8'h7F, 8'h02, 8'hFF};
      logic       vs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      int         vk [4] = '{1, 1, 4, 4};
      logic [2:0] vr [4] = '{3'b001, 3'b100, 3'b001, 3'b100};
      for (int i = 0; i < 4; i++) begin
         int lat, bad;
         logic [2:0] res;
         issue8(va[i], vb[i], vs[i], lat, res, bad);
         checks++;
         if (lat !== vk[i]) begin
            errors++;
            $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, vk[i]);
         end
         checks++;
         if (res !== vr[i]) begin
            errors++;
            $display("FAIL vec%0d_result it/eq/gt: got %b want %b", i, res, vr[i]);
         end
         checks++;
         if (bad !== 0) begin errors++; $display("FAIL vec%0d_cmp_outputs: %0d bad cycles want 0", i, bad); end
         @(negedge clk);
         checks++;
         if ({b8.done, b8.it, b8.eq, b8.gt} !== {1'b0, vr[i]}) begin
            errors++;
            $display("FAIL vec%0d_hold: done/it/eq/gt got %b want 0%b", i,
                     {b8.done, b8.it, b8.eq, b8.gt}, vr[i]);
         end
      end
   endtask

   task automatic test_busy_protect();
      int lat;
      @(negedge clk);
      b8.start = 1'b1; b8.a = 8'h10; b8.b = 8'h20; b8.sgn = 1'b0;
      @(negedge clk);
      b8.a = 8'hFF; b8.b = 8'h00;          // start still high while busy
      @(negedge clk);
      b8.start = 1'b0;
      lat = 1;
      while (!b8.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL busy_latency: got %0d want 2", lat); end
      checks++;
      if ({b8.it, b8.eq, b8.gt} !== 3'b100) begin
         errors++;
         $display("FAIL busy_result it/eq/gt: got %b want 100", {b8.it, b8.eq, b8.gt});
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({b8.busy, b8.done} !== 2'b00) begin
            errors++;
            $display("FAIL busy_back_to_idle %0d: busy/done got %b want 00", i, {b8.busy, b8.done});
         end
      end
   endtask

   task automatic test_reset_mid();
      int saw_done, lat, bad;
      logic [2:0] res;
      @(negedge clk);
      b8.start = 1'b1; b8.a = 8'h01; b8.b = 8'h01; b8.sgn = 1'b0;
      @(negedge clk);                      // E0 passed
      b8.start = 1'b0;
      @(negedge clk);                      // E1 passed
      rst_b = 1'b0;
      @(negedge clk);                      // reset taken at E2
      checks++;
      if ({b8.busy, b8.done, b8.it, b8.eq, b8.gt} !== 5'b00000) begin
         errors++;
         $display("FAIL midreset_outputs: got %b want 00000", {b8.busy, b8.done, b8.it, b8.eq, b8.gt});
      end
      rst_b = 1'b1;
      saw_done = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (b8.done || b8.busy) saw_done++;
      end
      checks++;
      if (saw_done !== 0) begin errors++; $display("FAIL midreset_no_done: %0d active cycles want 0", saw_done); end
      issue8(8'h01, 8'h00, 1'b0, lat, res, bad);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL fresh_latency: got %0d want 4", lat); end
      checks++;
      if (res !== 3'b001) begin errors++; $display("FAIL fresh_result it/eq/gt: got %b want 001", res); end
   endtask

   task automatic test_sweep16();
      for (int v = 0; v < 1000; v++) begin
         logic [15:0] va, vb;
         logic        vs, d1, d4;
         logic [2:0]  r1, r4, exp;
         int          k1, k4, l1, l4, cyc, mode;
         va = 16'($urandom);
         mode = $urandom_range(0, 3);
         if (mode == 0)      vb = va;
         else if (mode == 1) vb = va ^ (16'd1 << $urandom_range(0, 15));
         else                vb = 16'($urandom);
         vs = 1'($urandom_range(0, 1));
         @(negedge clk);
         b16a.start = 1'b1; b16a.a = va; b16a.b = vb; b16a.sgn = vs;
         b16b.start = 1'b1; b16b.a = va; b16b.b = vb; b16b.sgn = vs;
         @(negedge clk);
         b16a.start = 1'b0; b16b.start = 1'b0;
         cyc = 0; d1 = 1'b0; d4 = 1'b0; l1 = 0; l4 = 0; r1 = 3'b000; r4 = 3'b000;
         while (!(d1 && d4) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (b16a.done && !d1) begin d1 = 1'b1; l1 = cyc; r1 = {b16a.it, b16a.eq, b16a.gt}; end
            if (b16b.done && !d4) begin d4 = 1'b1; l4 = cyc; r4 = {b16b.it, b16b.eq, b16b.gt}; end
         end
         if (vs) exp = ($signed(va) < $signed(vb)) ? 3'b100 : ((va == vb) ? 3'b010 : 3'b001);
         else    exp = (va < vb) ? 3'b100 : ((va == vb) ? 3'b010 : 3'b001);
         k1 = ref_k(va, vb, 1);
         k4 = ref_k(va, vb, 4);
         checks++;
         if (!d1 || l1 !== k1 || l1 < 1 || l1 > 16) begin
            errors++;
            $display("FAIL sweep_c1_latency a=%h b=%h s=%b: got %0d (done=%b) want %0d", va, vb, vs, l1, d1, k1);
         end
         checks++;
         if (!d4 || l4 !== k4 || l4 < 1 || l4 > 4) begin
            errors++;
            $display("FAIL sweep_c4_latency a=%h b=%h s=%b: got %0d (done=%b) want %0d", va, vb, vs, l4, d4, k4);
         end
         checks++;
         if (r1 !== exp) begin
            errors++;
            $display("FAIL sweep_c1_result a=%h b=%h s=%b: got %b want %b", va, vb, vs, r1, exp);
         end
         checks++;
         if (r4 !== exp) begin
            errors++;
            $display("FAIL sweep_c4_result a=%h b=%h s=%b: got %b want %b", va, vb, vs, r4, exp);
         end
      end
   endtask

   initial begin
      b8.start = 1'b0;   b8.sgn = 1'b0;   b8.a = '0;   b8.b = '0;
      b16a.start = 1'b0; b16a.sgn = 1'b0; b16a.a = '0; b16a.b = '0;
      b16b.start = 1'b0; b16b.sgn = 1'b0; b16b.a = '0; b16b.b = '0;
      test_reset();
      test_equal();
      test_early_and_last();
      test_busy_protect();
      test_reset_mid();
      test_sweep16();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_mag_cmp.md
Name: seq_mag_cmp

Overview:
- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands.
- Scans MSB-first, CHUNK bits per clock, and terminates early at the first differing chunk.
- Supports unsigned and two's-complement signed modes, with a start/busy/done handshake.
- Serves as the reusable compare engine for datapaths wider than the 2-bit combinational comparator stage.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of CHUNK, >= CHUNK.
- CHUNK, 2, bits compared per clock cycle (1, 2, 4 or 8).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_b  in  1  synchronous active-low reset.
- start  in  1  request a comparison; sampled only in IDLE.
- sgn  in  1  1 = signed (two's complement) compare, 0 = unsigned; latched with start.
- a  in  WIDTH  operand A; latched with start.
- b  in  WIDTH  operand B; latched with start.
- busy  out  1  high in CMP and DONE states.
- done  out  1  one-cycle pulse; it/eq/gt are valid in that cycle.
- it  out  1  A < B.
- eq  out  1  A == B.
- gt  out  1  A > B.

Behaviour:
- Reset (rst_b=0 at a rising edge):
  - state=IDLE; busy, done, it, eq, gt all 0; shift registers cleared.
  - Reset has priority over every other event, including mid-compare: the operation is abandoned and no done pulse occurs.
- FSM states: IDLE, CMP, DONE. Encoding constants live in the package.
- IDLE:
  - On start=1, latch a, b, sgn into internal shift registers sa, sb.
  - Clear it/eq/gt to 0, clear the chunk counter, go to CMP.
  - Call this accepting edge E0.
- CMP, one chunk per edge:
  - Compare the top CHUNK bits of sa and sb.
  - Signed mode: for the first chunk only, the MSB of each operand is inverted before comparing (offset-binary trick), so signed ordering falls out of an unsigned compare. Later chunks are never modified.
  - Chunk differs: set it or gt from the chunk result, eq=0, go to DONE.
  - Chunk equal, not last: shift sa, sb left by CHUNK; increment counter; stay in CMP.
  - Chunk equal, last (counter == WIDTH/CHUNK-1): set eq=1, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - start is ignored in DONE.
- Latency: the decision is made at edge Ek, where k is the 1-based index of the first differing chunk (k = WIDTH/CHUNK if equal). done is high between Ek and Ek+1.
  - Minimum 1 cycle from E0 to the done cycle; maximum WIDTH/CHUNK.
- Result hold: it/eq/gt are registered and held stable after done until the next accepted start or reset.
  - Exactly one of them is 1 whenever it is held valid.
  - All three are 0 during CMP.
- Input changes: start while busy is ignored; a/b/sgn changes while busy have no effect on the running compare.
- Counter width: clog2(WIDTH/CHUNK), minimum 1 bit. No wrap-around is possible because the last-chunk check forces DONE.

Decomposition:
- Package (seq_mag_cmp_pkg): FSM state encoding constants (IDLE, CMP, DONE).
- One sub-module, cmp_chunk: purely combinational CHUNK-bit unsigned comparator with outputs it/eq/gt. It is instantiated once in seq_mag_cmp on the current top chunks.
- The FSM, shift registers, counter and result registers stay in the top module.

Test Plan (WIDTH=8, CHUNK=2 unless noted):
- Reset: hold rst_b=0 for 2 cycles with start=1 -> busy=done=it=eq=gt=0 throughout; IDLE after release.
- Equal operands: a=8'h5A, b=8'h5A, sgn=0, start pulse -> 4 CMP cycles, then done=1 with eq=1, it=gt=0; outputs held after done.
- Early termination, both modes:
  - a=8'h80, b=8'h7F, sgn=0 -> done 1 cycle after E0, gt=1.
  - Same operands, sgn=1 -> done 1 cycle after E0, it=1 (-128 < 127).
- Last-chunk difference and signed negatives:
  - a=8'h03, b=8'h02, sgn=0 -> done 4 cycles after E0, gt=1.
  - a=8'hFE, b=8'hFF, sgn=1 -> done 4 cycles after E0, it=1.
- Busy protection: start a=8'h10, b=8'h20; one cycle later assert start with a=8'hFF, b=8'h00 -> second request ignored; result it=1 at done, then IDLE.
- Reset mid-operation plus parameter sweep:
  - Start a=8'h01, b=8'h01, assert rst_b=0 at E2 -> no done pulse, outputs 0, IDLE.
  - Fresh start a=8'h01, b=8'h00 -> gt=1 after 4 cycles.
  - Repeat the random sweep (1000 vectors vs a reference model) with WIDTH=16, CHUNK=1 and CHUNK=4, checking latency bounds.
